alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: RR_INIT, 0, requester given priority first after reset (0 or 1).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: req0 / req1  input  1  request from requester 0 / 1, held until granted.
REQ-005 SHALL have ports: op0 / op1  input  3  ALU control code of requester 0 / 1.
REQ-006 SHALL have ports: a0, b0 / a1, b1  input  32  operands of requester 0 / 1.
REQ-007 SHALL have ports: gnt0 / gnt1  output  1  one-cycle accept pulse; operands captured this cycle.
REQ-008 SHALL have port: rsp_valid  output  1  one-cycle pulse, response fields valid.
REQ-009 SHALL have port: rsp_id  output  1  requester owning the current response.
REQ-010 SHALL have port: result  output  32  registered ALU result.
REQ-011 SHALL have ports: zero, neg, ovf, err  output  1  registered Z, N, V flags and illegal-opcode flag.
REQ-012 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; one operation in flight at a time.
REQ-014 In IDLE with any req high: grant one requester, latch its op/a/b, set owner, go EXEC; else stay IDLE.
REQ-015 Arbitration: only one requester -> grant it; both -> grant the one named by priority pointer.
REQ-016 Priority pointer SHALL switch to the non-granted requester after every grant (round-robin).
REQ-017 gnt0/gnt1 SHALL be asserted only in IDLE, never both in the same cycle.
REQ-018 EXEC: drive latched operands into the shared ALU; register result and flags at end of cycle; go DONE.
REQ-019 DONE: rsp_valid=1, rsp_id=owner for exactly one cycle; go IDLE.
REQ-020 Latency: grant in cycle T -> rsp_valid in cycle T+2; max throughput one operation per 3 cycles.
REQ-021 Requests are ignored in EXEC and DONE; a still-asserted req is served on a later IDLE cycle.
REQ-022 Opcodes: 010 ADD, 110 SUB (a-b, two's complement), 111 SLT (1 if signed a<b else 0), 000 AND, 001 OR.
REQ-023 All arithmetic modulo 2^32; carry out discarded.
REQ-024 ovf: ADD -> a[31]==b[31] and r[31]!=a[31]; SUB -> a[31]!=b[31] and r[31]!=a[31]; others 0.
REQ-025 neg: SLT -> bit 31 of a-b; other legal ops -> result[31].
REQ-026 zero SHALL equal (result==0), computed from the current operation's result.
REQ-027 Illegal opcode: result=0, zero=1, neg=0, ovf=0, err=1; response still issued normally.
REQ-028 err=0 for all legal opcodes.
REQ-029 result/flags/err/rsp_id SHALL hold their values until the next EXEC overwrites them.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, pointer=RR_INIT, all outputs 0.
REQ-031 Reset during EXEC or DONE SHALL abort the operation; no rsp_valid is produced for it.
REQ-032 First grant SHALL be possible in the first rising edge after rst_n deasserts.

Structure
REQ-033 Opcode constants and FSM state encodings SHALL reside in a shared ALU package.
REQ-034 The combinational ALU SHALL be one sub-module instance named alu32; flag logic lives in alu_arbiter.

Verification
REQ-035 req0 only, op=010, a=5, b=7 -> gnt0 at T, rsp_valid at T+2, rsp_id=0, result=12, zero=neg=ovf=err=0.
REQ-036 req0 and req1 together from reset (RR_INIT=0), held -> grants gnt0, gnt1, gnt0 alternating every 3 cycles.
REQ-037 op=010, a=0x7FFFFFFF, b=1 -> result=0x80000000, ovf=1, neg=1; op=110, a=0x80000000, b=1 -> result=0x7FFFFFFF, ovf=1, neg=0.
REQ-038 op=111, a=0xFFFFFFFF (-1), b=1 -> result=1, neg=1; op=110, a=b=0x1234 -> result=0, zero=1.
REQ-039 op=011, a=3, b=4 -> result=0, zero=1, err=1, rsp_valid issued at T+2.
REQ-040 rst_n pulsed low in EXEC -> busy=0 and all outputs 0 immediately, no rsp_valid; next req granted normally.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared opcode and FSM encodings for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic op_legal(input logic [2:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; exports the a-b sign bit so SLT's neg flag can be derived outside.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        diff_msb
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic        slt;

  always_comb begin
    sum      = a + b;
    diff     = a - b;
    slt      = ($signed(a) < $signed(b));
    diff_msb = diff[31];
    y        = '0;
    case (op)
      OP_ADD:  y = sum;
      OP_SUB:  y = diff;
      OP_SLT:  y = {31'b0, slt};
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters: grant, execute, respond (3 cycles).
// Handshake: reqN is held until gntN pulses; gntN marks the cycle opN/aN/bN are captured.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  op0,
  input  logic [2:0]  op1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] result,
  output logic        zero,
  output logic        neg,
  output logic        ovf,
  output logic        err,
  output logic        busy
);

  logic [1:0]  state;
  logic        ptr;
  logic        owner;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  logic        grant;
  logic        pick0;
  logic        pick1;
  logic [31:0] y;
  logic        diff_msb;
  logic        ovf_c;
  logic        neg_c;

  // ptr names the requester that wins when both ask at once.
  assign pick1 = req1 && (!req0 || ptr);
  assign pick0 = req0 && (!req1 || !ptr);
  assign grant = (state == ST_IDLE) && (req0 || req1);

  // Gated by rst_n so a held request cannot show a grant while reset is asserted.
  assign gnt0      = rst_n && grant && pick0;
  assign gnt1      = rst_n && grant && pick1;
  assign rsp_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  alu_arbiter_alu alu32 (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .y        (y),
    .diff_msb (diff_msb)
  );

  always_comb begin
    ovf_c = 1'b0;
    neg_c = 1'b0;
    case (op_q)
      OP_ADD: begin
        ovf_c = (a_q[31] == b_q[31]) && (y[31] != a_q[31]);
        neg_c = y[31];
      end
      OP_SUB: begin
        ovf_c = (a_q[31] != b_q[31]) && (y[31] != a_q[31]);
        neg_c = y[31];
      end
      OP_SLT:        neg_c = diff_msb;
      OP_AND, OP_OR: neg_c = y[31];
      default:       neg_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ptr    <= RR_INIT;
      owner  <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rsp_id <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            op_q  <= pick1 ? op1 : op0;
            a_q   <= pick1 ? a1 : a0;
            b_q   <= pick1 ? b1 : b0;
            owner <= pick1;
            ptr   <= !pick1;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result <= y;
          zero   <= (y == '0);
          neg    <= neg_c;
          ovf    <= ovf_c;
          err    <= !op_legal(op_q);
          rsp_id <= owner;
          state  <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
